// File: rtl/usb_tx_arbiter.sv
// usb_tx_arbiter: schedules the shared USB tx datapath between the handshake
// requester (ACK/NAK/STALL) and the data requester. It issues one-cycle start
// pulses, tracks `transmitting` to detect completion, enforces an
// inter-packet gap and start/packet timeouts, and bounds handshake streaks
// so pending data is not starved.
module usb_tx_arbiter #(
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 64,
  parameter int PKT_TIMEOUT   = 8192,
  parameter int HS_STREAK_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic hs_req,
  input  logic data_req,
  input  logic transmitting,
  output logic transmit_start,
  output logic transmit_response,
  output logic grant_hs,
  output logic grant_data,
  output logic hs_ack,
  output logic data_ack,
  output logic hs_err,
  output logic data_err,
  output logic busy
);

  localparam int TO_MAX = (START_TIMEOUT > PKT_TIMEOUT) ? START_TIMEOUT : PKT_TIMEOUT;
  localparam int TO_W   = $clog2(TO_MAX + 1);
  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int STK_W  = (HS_STREAK_MAX > 0) ? $clog2(HS_STREAK_MAX + 1) : 1;

  localparam logic [TO_W-1:0]  START_LAST = TO_W'(START_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  PKT_LAST   = TO_W'(PKT_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
  localparam logic [STK_W-1:0] STK_MAX    = STK_W'(HS_STREAK_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_TX, S_BUSY, S_DONE, S_GAP
  } state_e;

  // owner encoding: 0 = handshake, 1 = data
  state_e           state_q, state_d;
  logic             own_q, own_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [STK_W-1:0] stk_q, stk_d;

  logic start_q, start_d, resp_q, resp_d;
  logic ghs_q, ghs_d, gdat_q, gdat_d;
  logic hack_q, hack_d, dack_q, dack_d;
  logic herr_q, herr_d, derr_q, derr_d;
  logic busy_q, busy_d;

  logic pick_hs, fin_err, in_pkt;

  // Next-state, counters and the values every output takes next cycle
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    to_d    = to_q;
    gap_d   = gap_q;
    stk_d   = stk_q;
    fin_err = 1'b0;
    pick_hs = hs_req && !(data_req && (stk_q == STK_MAX));

    case (state_q)
      S_IDLE: begin
        if (pick_hs) begin
          state_d = S_START;
          own_d   = 1'b0;
          to_d    = '0;
          // streak only grows while data is actually waiting
          if (data_req) stk_d = (stk_q == STK_MAX) ? stk_q : stk_q + STK_W'(1);
          else          stk_d = '0;
        end else if (data_req) begin
          state_d = S_START;
          own_d   = 1'b1;
          to_d    = '0;
          stk_d   = '0;
        end
      end
      S_START: begin
        state_d = S_WAIT_TX;
        to_d    = '0;
      end
      S_WAIT_TX: begin
        if (transmitting) begin
          state_d = S_BUSY;
          to_d    = '0;
        end else if (to_q == START_LAST) begin
          fin_err = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_BUSY: begin
        if (!transmitting) begin
          state_d = S_DONE;
        end else if (to_q == PKT_LAST) begin
          // datapath is left to drain by itself
          fin_err = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_DONE: begin
        state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        gap_d   = '0;
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (fin_err) begin
      state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      gap_d   = '0;
    end

    // the error cycle still shows the owner's grant; it drops the cycle after
    in_pkt  = fin_err || (state_d inside {S_START, S_WAIT_TX, S_BUSY, S_DONE});
    start_d = (state_d == S_START) &&  own_d;
    resp_d  = (state_d == S_START) && !own_d;
    ghs_d   = in_pkt && !own_d;
    gdat_d  = in_pkt &&  own_d;
    hack_d  = (state_d == S_DONE) && !own_d;
    dack_d  = (state_d == S_DONE) &&  own_d;
    herr_d  = fin_err && !own_d;
    derr_d  = fin_err &&  own_d;
    busy_d  = (state_d != S_IDLE);
  end

  // State, counters and registered outputs; reset aborts any packet silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      own_q   <= 1'b0;
      to_q    <= '0;
      gap_q   <= '0;
      stk_q   <= '0;
      start_q <= 1'b0;
      resp_q  <= 1'b0;
      ghs_q   <= 1'b0;
      gdat_q  <= 1'b0;
      hack_q  <= 1'b0;
      dack_q  <= 1'b0;
      herr_q  <= 1'b0;
      derr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      to_q    <= to_d;
      gap_q   <= gap_d;
      stk_q   <= stk_d;
      start_q <= start_d;
      resp_q  <= resp_d;
      ghs_q   <= ghs_d;
      gdat_q  <= gdat_d;
      hack_q  <= hack_d;
      dack_q  <= dack_d;
      herr_q  <= herr_d;
      derr_q  <= derr_d;
      busy_q  <= busy_d;
    end
  end

  assign transmit_start    = start_q;
  assign transmit_response = resp_q;
  assign grant_hs          = ghs_q;
  assign grant_data        = gdat_q;
  assign hs_ack            = hack_q;
  assign data_ack          = dack_q;
  assign hs_err            = herr_q;
  assign data_err          = derr_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Bench for usb_tx_arbiter: reset check, a table of single-packet vectors,
// directed multi-cycle sequences and a randomized run against a
// packet-level timing model.
module tb_usb_tx_arbiter;
  localparam int G    = 16;
  localparam int TST  = 64;
  localparam int TPK  = 8192;
  localparam int SMAX = 4;
  localparam int NR   = 6000;

  logic clk = 1'b0;
  logic rst, hs_req, data_req, transmitting;
  logic transmit_start, transmit_response, grant_hs, grant_data;
  logic hs_ack, data_ack, hs_err, data_err, busy;
  logic [8:0] outs;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  usb_tx_arbiter #(.GAP_CYCLES(G), .START_TIMEOUT(TST), .PKT_TIMEOUT(TPK),
                   .HS_STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .hs_req(hs_req), .data_req(data_req),
    .transmitting(transmitting), .transmit_start(transmit_start),
    .transmit_response(transmit_response), .grant_hs(grant_hs),
    .grant_data(grant_data), .hs_ack(hs_ack), .data_ack(data_ack),
    .hs_err(hs_err), .data_err(data_err), .busy(busy));

  assign outs = {transmit_start, transmit_response, grant_hs, grant_data,
                 hs_ack, data_ack, hs_err, data_err, busy};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // grants exclusive, ack/err never together
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((grant_hs && grant_data) || ((hs_ack || data_ack) && (hs_err || data_err))) begin
        bad++;
        $display("FAIL exclusive: grants=%b%b ack=%b%b err=%b%b", grant_hs, grant_data,
                 hs_ack, data_ack, hs_err, data_err);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; hs_req = 1'b0; data_req = 1'b0; transmitting = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Waits for the next start pulse, then drives transmitting d cycles into
  // WAIT_TX for L cycles (d<0: never) until an ack/err shows up.
  task automatic serve_one(input int d, input int L, output logic own_data,
                           output int s_cyc, output int e_cyc, output logic was_err);
    int n, o;
    n = 0; own_data = 1'b0; s_cyc = 0; e_cyc = 0; was_err = 1'b0;
    while (!(transmit_start || transmit_response) && n < 300) begin tick(); n++; end
    if (!(transmit_start || transmit_response)) begin
      chk("serve start seen", 0, 1);
      return;
    end
    own_data = transmit_start; s_cyc = cyc; o = 0;
    while (1) begin
      tick(); o++;
      if (hs_ack || data_ack || hs_err || data_err) break;
      if (o > 9000) begin chk("serve end seen", 0, 1); return; end
      transmitting = (d >= 0 && o >= 1 + d && o < 1 + d + L);
    end
    e_cyc = cyc; was_err = hs_err || data_err;
  endtask

  typedef struct {
    logic hs;
    logic dat;
    int   d;
    int   len;
    logic exp_data;
    logic exp_err;
    int   exp_off;
  } vec_t;

  vec_t tbl [7];

  task automatic run_vec(input int idx, input vec_t v);
    int stray;
    logic [5:0] exp_end;
    stray = 0;
    exp_end[5:4] = v.exp_err ? 2'b00 : (v.exp_data ? 2'b01 : 2'b10);
    exp_end[3:2] = v.exp_err ? (v.exp_data ? 2'b01 : 2'b10) : 2'b00;
    exp_end[1:0] = v.exp_data ? 2'b01 : 2'b10;
    hs_req = v.hs; data_req = v.dat; transmitting = 1'b0;
    tick();
    chk($sformatf("vec%0d start pulse", idx), 32'({transmit_start, transmit_response}),
        v.exp_data ? 32'd2 : 32'd1);
    chk($sformatf("vec%0d grant", idx), 32'({grant_hs, grant_data}), v.exp_data ? 32'd1 : 32'd2);
    for (int o = 1; o <= v.exp_off + G + 3; o++) begin
      tick();
      if (o == v.exp_off) begin
        chk($sformatf("vec%0d end", idx),
            32'({hs_ack, data_ack, hs_err, data_err, grant_hs, grant_data}), 32'(exp_end));
        hs_req = 1'b0; data_req = 1'b0;
      end else begin
        stray += int'(hs_ack) + int'(data_ack) + int'(hs_err) + int'(data_err);
      end
      if (o == v.exp_off + 1)
        chk($sformatf("vec%0d grant drop", idx), 32'({grant_hs, grant_data}), 0);
      stray += int'(transmit_start) + int'(transmit_response);
      transmitting = (v.d >= 0 && o >= 1 + v.d && o < 1 + v.d + v.len);
    end
    chk($sformatf("vec%0d stray pulses", idx), 32'(stray), 0);
    chk($sformatf("vec%0d idle busy", idx), 32'(busy), 0);
  endtask

  // randomized-run model storage
  logic [8:0] exp_o [0:NR+255];
  bit         tx_plan [0:NR+255];

  initial begin
    logic od, werr, od2, werr2;
    int s1, e1, s2, e2, c0, r, n;
    int free_at, last_e, cur_s, cur_e, streak, d, len, s, e, idle;
    logic cur_act, cur_own, hs_pend, dt_pend, pick_hs, gotit;

    // hs, data, d, len, data-owner, err, completion offset from START
    tbl[0] = '{1'b1, 1'b0,  1, 28, 1'b0, 1'b0, 31};
    tbl[1] = '{1'b0, 1'b1,  0,  1, 1'b1, 1'b0,  3};
    tbl[2] = '{1'b0, 1'b1, 63,  5, 1'b1, 1'b0, 70};
    tbl[3] = '{1'b0, 1'b1, -1,  0, 1'b1, 1'b1, 65};
    tbl[4] = '{1'b1, 1'b1,  2,  3, 1'b0, 1'b0,  7};
    tbl[5] = '{1'b0, 1'b1, 64,  4, 1'b1, 1'b1, 65};
    tbl[6] = '{1'b1, 1'b0,  0,  1, 1'b0, 1'b0,  3};

    do_reset();
    chk("reset outputs", 32'(outs), 0);
    tick();
    chk("idle no request", 32'(outs), 0);

    for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

    // simultaneous requests: handshake first, data G+2 after hs DONE
    do_reset();
    hs_req = 1'b1; data_req = 1'b1; c0 = cyc;
    serve_one(0, 2, od, s1, e1, werr);
    chk("simul first owner", 32'(od), 0);
    chk("simul latency", 32'(s1 - c0), 1);
    chk("simul hs ack", 32'({hs_ack, werr}), 32'd2);
    hs_req = 1'b0; transmitting = 1'b0;
    serve_one(0, 2, od, s2, e2, werr);
    chk("simul second owner", 32'(od), 1);
    chk("simul data start gap", 32'(s2 - e1), 32'(G + 2));
    data_req = 1'b0;

    // starvation bound: 4 handshakes, then data, then handshake again
    do_reset();
    hs_req = 1'b1; data_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      serve_one(0, 1, od, s1, e1, werr);
      chk($sformatf("streak grant %0d", k), 32'(od), (k == 4) ? 32'd1 : 32'd0);
      transmitting = 1'b0;
    end
    hs_req = 1'b0; data_req = 1'b0;

    // start timeout on data
    do_reset();
    data_req = 1'b1;
    serve_one(-1, 0, od, s1, e1, werr);
    chk("start to owner", 32'(od), 1);
    chk("start to offset", 32'(e1 - s1), 32'(1 + TST));
    chk("start to pulses", 32'({hs_ack, data_ack, hs_err, data_err, grant_data}), 32'b00011);
    data_req = 1'b0; hs_req = 1'b1;
    tick();
    chk("start to grant drop", 32'({grant_hs, grant_data}), 0);
    serve_one(0, 1, od, s2, e2, werr);
    chk("start to resume", 32'({od, werr}), 0);
    chk("start to resume time", 32'(s2 - e1), 32'(G + 1));
    hs_req = 1'b0; transmitting = 1'b0;

    // packet timeout with transmitting stuck high, pending data afterwards
    do_reset();
    hs_req = 1'b1; data_req = 1'b1;
    serve_one(0, 1 << 30, od, s1, e1, werr);
    chk("pkt to owner", 32'(od), 0);
    chk("pkt to offset", 32'(e1 - s1), 32'(2 + TPK));
    chk("pkt to pulses", 32'({hs_ack, data_ack, hs_err, data_err}), 32'b0010);
    hs_req = 1'b0;
    n = 0;
    while (!transmit_start && n < G + 8) begin tick(); n++; end
    chk("pkt to data start", 32'({transmit_start, grant_data}), 32'b11);
    chk("pkt to data time", 32'(cyc - e1), 32'(G + 1));
    tick(); tick();
    transmitting = 1'b0; data_req = 1'b0;
    tick();
    chk("pkt to data ack", 32'({data_ack, data_err}), 32'b10);

    // reset in the middle of a data packet
    do_reset();
    data_req = 1'b1;
    tick();
    chk("rst seq start", 32'(transmit_start), 1);
    tick(); transmitting = 1'b1;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst seq outputs", 32'(outs), 0);
    rst = 1'b0; transmitting = 1'b0;
    tick();
    chk("rst seq restart", 32'({transmit_start, grant_data}), 32'b11);
    tick(); transmitting = 1'b1;
    tick(); transmitting = 1'b0;
    tick();
    chk("rst seq ack", 32'({data_ack, data_err}), 32'b10);
    data_req = 1'b0;

    // randomized run against a packet-level timing model
    for (int k = 0; k < NR + 256; k++) begin exp_o[k] = '0; tx_plan[k] = 1'b0; end
    do_reset();
    free_at = 0; last_e = -1; streak = 0; cur_act = 1'b0; cur_own = 1'b0;
    cur_s = 0; cur_e = 0; hs_pend = 1'b0; dt_pend = 1'b0;
    for (int c = 0; c < NR; c++) begin
      if (c > 0) tick();
      total++;
      if (outs !== exp_o[c]) begin
        bad++;
        $display("FAIL random c=%0d: got %b expected %b", c, outs, exp_o[c]);
      end
      // requesters: hold until completion, occasionally let go while granted
      if (cur_act && c == cur_e) begin
        if (cur_own) begin data_req = 1'b0; dt_pend = 1'b0; end
        else         begin hs_req   = 1'b0; hs_pend = 1'b0; end
        cur_act = 1'b0;
      end else if (cur_act && c >= cur_s && $urandom_range(15) == 0) begin
        if (cur_own) data_req = 1'b0; else hs_req = 1'b0;
      end
      if (!hs_pend && $urandom_range(2) == 0) begin hs_req = 1'b1; hs_pend = 1'b1; end
      if (!dt_pend && $urandom_range(2) == 0) begin data_req = 1'b1; dt_pend = 1'b1; end
      // spurious transmitting only while the arbiter cannot be starting
      if (c > last_e && c <= free_at && $urandom_range(3) == 0) transmitting = 1'b1;
      else transmitting = tx_plan[c];
      // arbitrate when idle
      if (c >= free_at && (hs_req || data_req)) begin
        pick_hs = hs_req && !(data_req && streak >= SMAX);
        if (pick_hs) streak = data_req ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
        else         streak = 0;
        s = c + 1;
        d = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(63));
        len = int'($urandom_range(12, 1));
        if (d >= 0) begin
          for (int k = s + 1 + d; k <= s + d + len; k++) tx_plan[k] = 1'b1;
          e = s + 2 + d + len; idle = e + 1 + G;
        end else begin
          e = s + 1 + TST; idle = e + G;
        end
        for (int k = s; k <= e; k++) begin
          if (pick_hs) exp_o[k][6] = 1'b1; else exp_o[k][5] = 1'b1;
        end
        if (pick_hs) exp_o[s][7] = 1'b1; else exp_o[s][8] = 1'b1;
        if (d >= 0) begin
          if (pick_hs) exp_o[e][4] = 1'b1; else exp_o[e][3] = 1'b1;
        end else begin
          if (pick_hs) exp_o[e][2] = 1'b1; else exp_o[e][1] = 1'b1;
        end
        for (int k = s; k < idle; k++) exp_o[k][0] = 1'b1;
        free_at = idle; last_e = e;
        cur_act = 1'b1; cur_own = !pick_hs; cur_s = s; cur_e = e;
      end
    end
    gotit = 1'b1;
    r = 0;
    if (gotit) r = 1;
    chk("random run reached end", 32'(r), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
